// File: rtl/lsu_lsq_dtlb_arb.sv
// lsu_lsq_dtlb_arb
//   Translation requester for the load/store queue. Scans every LSQ entry for
//   ones that are valid, still carry a virtual tag and have no exception
//   recorded, picks one round-robin, and issues it as the single outstanding
//   request to the DTLB over a valid/ready handshake. The DTLB response is
//   routed back to the owning entry as a one-hot update strobe plus broadcast
//   tag / virt / exception buses.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   flush                         pipeline flush (synchronous)
//   lsq_entry_vld_i               per-entry valid
//   lsq_entry_alloc_i             per-entry (re)allocation pulse
//   lsq_entry_virt_i              per-entry "tag still virtual"
//   lsq_entry_exception_vld_i     per-entry exception already recorded
//   lsq_entry_ls_i                per-entry type, 1 = store, 0 = load
//   lsq_entry_vtag_i              packed vtags, entry k at [k*VTAG +: VTAG]
//   dtlb_req_vld_o/rdy_i          request handshake
//   dtlb_req_vtag_o, dtlb_req_ls_o  request payload
//   dtlb_resp_*                   single-cycle response from the DTLB
//   dtlb_lsq_entry_vld_o          one-hot entry update strobe
//   dtlb_lsq_entry_virt_o/tag_o/exception_vld_o/ecause_o  broadcast update
//
// Optional build macro LSU_DTLB_ARB_PERF_CNT_EN adds two wrapping 32-bit
// counters: dtlb_req_cnt_o (request handshakes) and dtlb_wait_cycle_cnt_o
// (cycles spent waiting for or draining a response).

module lsu_lsq_dtlb_arb #(
   parameter int LSQ_ENTRY_NUM         = 8,
   parameter int LSQ_ENTRY_NUM_WIDTH   = 3,
   parameter int VIRTUAL_ADDR_TAG_LEN  = 27,
   parameter int LSQ_ENTRY_TAG_WIDTH   = 44,
   parameter int EXCEPTION_CAUSE_WIDTH = 4
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic                                            flush,
   input  logic [LSQ_ENTRY_NUM-1:0]                        lsq_entry_vld_i,
   input  logic [LSQ_ENTRY_NUM-1:0]                        lsq_entry_alloc_i,
   input  logic [LSQ_ENTRY_NUM-1:0]                        lsq_entry_virt_i,
   input  logic [LSQ_ENTRY_NUM-1:0]                        lsq_entry_exception_vld_i,
   input  logic [LSQ_ENTRY_NUM-1:0]                        lsq_entry_ls_i,
   input  logic [LSQ_ENTRY_NUM*VIRTUAL_ADDR_TAG_LEN-1:0]   lsq_entry_vtag_i,
   output logic                                            dtlb_req_vld_o,
   input  logic                                            dtlb_req_rdy_i,
   output logic [VIRTUAL_ADDR_TAG_LEN-1:0]                 dtlb_req_vtag_o,
   output logic                                            dtlb_req_ls_o,
   input  logic                                            dtlb_resp_vld_i,
   input  logic [LSQ_ENTRY_TAG_WIDTH-1:0]                  dtlb_resp_ptag_i,
   input  logic                                            dtlb_resp_exception_vld_i,
   input  logic [EXCEPTION_CAUSE_WIDTH-1:0]                dtlb_resp_ecause_i,
   output logic [LSQ_ENTRY_NUM-1:0]                        dtlb_lsq_entry_vld_o,
   output logic                                            dtlb_lsq_entry_virt_o,
   output logic [LSQ_ENTRY_TAG_WIDTH-1:0]                  dtlb_lsq_entry_tag_o,
   output logic                                            dtlb_lsq_entry_exception_vld_o,
   output logic [EXCEPTION_CAUSE_WIDTH-1:0]                dtlb_lsq_entry_ecause_o
`ifdef LSU_DTLB_ARB_PERF_CNT_EN
   ,
   output logic [31:0]                                     dtlb_req_cnt_o,
   output logic [31:0]                                     dtlb_wait_cycle_cnt_o
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_REQ   = 2'd1,
      S_WAIT  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                            state;
   state_t                            state_nxt;

   logic [LSQ_ENTRY_NUM_WIDTH-1:0]    rr_ptr;
   logic [LSQ_ENTRY_NUM_WIDTH-1:0]    idx_q;
   logic [VIRTUAL_ADDR_TAG_LEN-1:0]   vtag_q;
   logic                              ls_q;
   logic                              stale;

   logic [LSQ_ENTRY_NUM-1:0]          cand;
   logic                              pick_vld;
   logic [LSQ_ENTRY_NUM_WIDTH-1:0]    pick_idx;
   logic [LSQ_ENTRY_NUM_WIDTH-1:0]    scan_idx;
   logic                              take_pick;
   logic                              entry_lost;
   logic                              fwd;

   // ------------------------------------------------------------------
   // Candidate selection
   // ------------------------------------------------------------------
   assign cand = lsq_entry_vld_i & lsq_entry_virt_i &
                 ~lsq_entry_exception_vld_i & ~lsq_entry_alloc_i;

   // First candidate at or above rr_ptr, wrapping. The index adder wraps
   // naturally because the entry count is a power of two.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      scan_idx = '0;
      for (int unsigned i = 0; i < LSQ_ENTRY_NUM; i++) begin
         scan_idx = rr_ptr + LSQ_ENTRY_NUM_WIDTH'(i);
         if (!pick_vld && cand[scan_idx]) begin
            pick_vld = 1'b1;
            pick_idx = scan_idx;
         end
      end
   end

   // The tracked entry went away (reallocated or invalidated) while its
   // translation was in flight; its response must not be written back.
   assign entry_lost = lsq_entry_alloc_i[idx_q] | ~lsq_entry_vld_i[idx_q];

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (!flush && pick_vld) state_nxt = S_REQ;
         end
         S_REQ: begin
            // A request accepted in the same cycle as a flush is already
            // owned by the DTLB, so its response still has to be drained.
            if (dtlb_req_rdy_i)  state_nxt = flush ? S_DRAIN : S_WAIT;
            else if (flush)      state_nxt = S_IDLE;
         end
         S_WAIT: begin
            if (dtlb_resp_vld_i) state_nxt = S_IDLE;
            else if (flush)      state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (dtlb_resp_vld_i) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign take_pick = (state == S_IDLE) && (state_nxt == S_REQ);

   // ------------------------------------------------------------------
   // State and request registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         rr_ptr <= '0;
         stale  <= 1'b0;
         idx_q  <= '0;
         vtag_q <= '0;
         ls_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (take_pick) begin
            idx_q  <= pick_idx;
            vtag_q <= lsq_entry_vtag_i[pick_idx*VIRTUAL_ADDR_TAG_LEN +: VIRTUAL_ADDR_TAG_LEN];
            ls_q   <= lsq_entry_ls_i[pick_idx];
            stale  <= 1'b0;
            rr_ptr <= pick_idx + LSQ_ENTRY_NUM_WIDTH'(1);
         end else if (((state == S_REQ) || (state == S_WAIT)) && entry_lost) begin
            stale <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Request outputs
   // ------------------------------------------------------------------
   assign dtlb_req_vld_o  = (state == S_REQ);
   assign dtlb_req_vtag_o = vtag_q;
   assign dtlb_req_ls_o   = ls_q;

   // ------------------------------------------------------------------
   // Response forwarding (combinational, same cycle as the response)
   // ------------------------------------------------------------------
   assign fwd = dtlb_resp_vld_i && (state == S_WAIT) && !stale && !entry_lost;

   always_comb begin
      dtlb_lsq_entry_vld_o           = '0;
      dtlb_lsq_entry_virt_o          = 1'b0;
      dtlb_lsq_entry_tag_o           = '0;
      dtlb_lsq_entry_exception_vld_o = 1'b0;
      dtlb_lsq_entry_ecause_o        = '0;
      if (fwd) begin
         dtlb_lsq_entry_vld_o[idx_q]    = 1'b1;
         // A faulting translation leaves the entry virtual.
         dtlb_lsq_entry_virt_o          = dtlb_resp_exception_vld_i;
         dtlb_lsq_entry_tag_o           = dtlb_resp_ptag_i;
         dtlb_lsq_entry_exception_vld_o = dtlb_resp_exception_vld_i;
         dtlb_lsq_entry_ecause_o        = dtlb_resp_ecause_i;
      end
   end

   // ------------------------------------------------------------------
   // Optional performance counters (survive flush, cleared by rst)
   // ------------------------------------------------------------------
`ifdef LSU_DTLB_ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         dtlb_req_cnt_o        <= '0;
         dtlb_wait_cycle_cnt_o <= '0;
      end else begin
         if ((state == S_REQ) && dtlb_req_rdy_i)
            dtlb_req_cnt_o <= dtlb_req_cnt_o + 32'd1;
         if ((state == S_WAIT) || (state == S_DRAIN))
            dtlb_wait_cycle_cnt_o <= dtlb_wait_cycle_cnt_o + 32'd1;
      end
   end
`endif

endmodule
